// File: rtl/adjust_pkg.sv
// Shared types and constants for the adjust_v frame sequencer.
package adjust_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] from_v;
        logic [7:0] to_v;
    } cfg_t;

    localparam logic [7:0] DEF_FROM_V = 8'h00;
    localparam logic [7:0] DEF_TO_V   = 8'hFF;

endpackage

// File: rtl/adjust_cfg_fifo.sv
// Small config FIFO holding per-frame adjust bounds.
// A push into a full FIFO is still accepted when a pop happens in the same cycle.
module adjust_cfg_fifo
    import adjust_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  cfg_t push_data,
    input  logic pop,
    output cfg_t head,
    output logic full,
    output logic empty,
    output logic push_drop
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cfg_t       mem_q [DEPTH];
    cfg_t       mem_d [DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic        push_ok;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                       (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push_ok   = push && (!full || pop);
    assign push_drop = push && full && !pop;
    assign head      = mem_q[rd_ptr_q[AW-1:0]];

    // Next pointer and storage values for accepted pushes and pops.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (push_ok) begin
            mem_d[wr_ptr_q[AW-1:0]] = push_data;
            wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        end
        if (pop && !empty) begin
            rd_ptr_d = rd_ptr_q + (AW+1)'(1);
        end
    end

    // Pointers reset to empty, which discards any queued entries.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Entry storage needs no reset; the pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/adjust_frame_sched.sv
// Frame-level sequencer for the framebuf -> adjust_v -> framebuf pipeline.
// Admits exactly FRAME_PIX pixels per frame and holds adjust bounds until the
// frame's last output pixel leaves the pipeline.
// Optional STATS_EN macro adds frame_cnt and stall_cnt outputs.
module adjust_frame_sched
    import adjust_pkg::*;
#(
    parameter int FRAME_PIX = 4096,
    parameter int CNT_W     = 13,
    parameter int CFG_DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cfg_wr,
    input  logic [7:0] cfg_from_v,
    input  logic [7:0] cfg_to_v,
    output logic       cfg_full,
    output logic       cfg_err,
    output logic       up_req,
    input  logic       up_ack,
    input  logic       pipe_rcv_req,
    output logic       pipe_rcv_ack,
    input  logic       pipe_snd_req,
    input  logic       pipe_snd_ack,
    output logic [7:0] adjust_from_v,
    output logic [7:0] adjust_to_v,
    output logic       busy,
    output logic       frame_done
`ifdef STATS_EN
    ,
    output logic [15:0] frame_cnt,
    output logic [15:0] stall_cnt
`endif
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIX - 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FRAME_PIX);

    state_t           state_q, state_d;
    logic             gate_q, gate_d;
    logic [CNT_W-1:0] in_cnt_q, in_cnt_d;
    logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
    logic [7:0]       from_q, from_d;
    logic [7:0]       to_q, to_d;
    logic             frame_done_q, frame_done_d;
    logic             cfg_err_q, cfg_err_d;

    logic in_xfer, out_xfer, pop, fifo_empty, push_drop;
    cfg_t cfg_in, head;

    assign up_req        = pipe_rcv_req & gate_q;
    assign pipe_rcv_ack  = up_ack & gate_q;
    assign in_xfer       = up_req & up_ack;
    assign out_xfer      = pipe_snd_req & pipe_snd_ack;
    assign pop           = (state_q == LOAD);
    assign cfg_in        = {cfg_from_v, cfg_to_v};
    assign adjust_from_v = from_q;
    assign adjust_to_v   = to_q;
    assign busy          = (state_q != IDLE);
    assign frame_done    = frame_done_q;
    assign cfg_err       = cfg_err_q;

    adjust_cfg_fifo #(
        .DEPTH (CFG_DEPTH)
    ) u_cfg_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (cfg_wr),
        .push_data (cfg_in),
        .pop       (pop),
        .head      (head),
        .full      (cfg_full),
        .empty     (fifo_empty),
        .push_drop (push_drop)
    );

    // Next-state, gating and pixel accounting for the frame sequence.
    always_comb begin
        state_d      = state_q;
        gate_d       = gate_q;
        in_cnt_d     = in_cnt_q;
        out_cnt_d    = out_cnt_q;
        from_d       = from_q;
        to_d         = to_q;
        frame_done_d = 1'b0;
        cfg_err_d    = push_drop;

        // Output pixels are only meaningful once a frame is running.
        if ((state_q == RUN || state_q == DRAIN) && out_xfer) begin
            out_cnt_d = out_cnt_q + CNT_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (!fifo_empty) state_d = LOAD;
            end
            LOAD: begin
                from_d    = head.from_v;
                to_d      = head.to_v;
                in_cnt_d  = '0;
                out_cnt_d = '0;
                gate_d    = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                if (in_xfer) begin
                    in_cnt_d = in_cnt_q + CNT_W'(1);
                    // The last pixel is accepted this cycle; admission closes after it.
                    if (in_cnt_q == LAST_CNT) begin
                        gate_d  = 1'b0;
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if ((out_xfer && out_cnt_q == LAST_CNT) || out_cnt_q == FULL_CNT) begin
                    frame_done_d = 1'b1;
                    state_d      = fifo_empty ? IDLE : LOAD;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and output registers; reset closes the gate immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            gate_q       <= 1'b0;
            in_cnt_q     <= '0;
            out_cnt_q    <= '0;
            from_q       <= DEF_FROM_V;
            to_q         <= DEF_TO_V;
            frame_done_q <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gate_q       <= gate_d;
            in_cnt_q     <= in_cnt_d;
            out_cnt_q    <= out_cnt_d;
            from_q       <= from_d;
            to_q         <= to_d;
            frame_done_q <= frame_done_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

`ifdef STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    assign frame_cnt = frame_cnt_q;
    assign stall_cnt = stall_cnt_q;

    // Frame count wraps; stall count saturates.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        stall_cnt_d = stall_cnt_q;
        if (frame_done_d) frame_cnt_d = frame_cnt_q + 16'd1;
        if (pipe_rcv_req && !gate_q && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Statistics registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_adjust_frame_sched.sv
// Self-checking bench for adjust_frame_sched with a frame-level reference model.
module tb_adjust_frame_sched;

    localparam int FP    = 4;
    localparam int DEPTH = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       cfg_wr;
    logic [7:0] cfg_from_v, cfg_to_v;
    logic       cfg_full, cfg_err;
    logic       up_req, up_ack;
    logic       pipe_rcv_req, pipe_rcv_ack;
    logic       pipe_snd_req, pipe_snd_ack;
    logic [7:0] adjust_from_v, adjust_to_v;
    logic       busy, frame_done;
`ifdef STATS_EN
    logic [15:0] frame_cnt, stall_cnt;
`endif

    always #5 clk = ~clk;

    adjust_frame_sched #(
        .FRAME_PIX (FP),
        .CNT_W     (13),
        .CFG_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_wr        (cfg_wr),
        .cfg_from_v    (cfg_from_v),
        .cfg_to_v      (cfg_to_v),
        .cfg_full      (cfg_full),
        .cfg_err       (cfg_err),
        .up_req        (up_req),
        .up_ack        (up_ack),
        .pipe_rcv_req  (pipe_rcv_req),
        .pipe_rcv_ack  (pipe_rcv_ack),
        .pipe_snd_req  (pipe_snd_req),
        .pipe_snd_ack  (pipe_snd_ack),
        .adjust_from_v (adjust_from_v),
        .adjust_to_v   (adjust_to_v),
        .busy          (busy),
        .frame_done    (frame_done)
`ifdef STATS_EN
        ,
        .frame_cnt     (frame_cnt),
        .stall_cnt     (stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: a queue of pending frames plus remaining pixel budgets.
    logic [15:0] cfgq[$];
    logic [7:0]  m_from, m_to;
    bit          m_active, m_load, m_done, m_err;
    int          m_in_left, m_out_left, pipe_n;
    int          m_frames, m_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        cfgq.delete();
        m_from = 8'h00; m_to = 8'hFF;
        m_active = 0; m_load = 0; m_done = 0; m_err = 0;
        m_in_left = 0; m_out_left = 0; pipe_n = 0;
        m_frames = 0; m_stall = 0;
    endtask

    function automatic bit m_gate();
        return m_active && !m_load && (m_in_left > 0);
    endfunction

    task automatic check_outputs();
        bit g;
        g = m_gate();
        chk("up_req",       up_req,        g & pipe_rcv_req);
        chk("pipe_rcv_ack", pipe_rcv_ack,  g & up_ack);
        chk("cfg_full",     cfg_full,      cfgq.size() == DEPTH);
        chk("cfg_err",      cfg_err,       m_err);
        chk("adjust_from",  adjust_from_v, m_from);
        chk("adjust_to",    adjust_to_v,   m_to);
        chk("busy",         busy,          m_active);
        chk("frame_done",   frame_done,    m_done);
`ifdef STATS_EN
        chk("frame_cnt",    frame_cnt,     m_frames);
        chk("stall_cnt",    stall_cnt,     m_stall);
`endif
    endtask

    // Advance the model across one rising edge using the current inputs.
    task automatic model_step();
        bit g, in_x, out_x, popping;
        int sz0;
        g       = m_gate();
        in_x    = g && pipe_rcv_req && up_ack;
        out_x   = pipe_snd_req && pipe_snd_ack && m_active && !m_load;
        sz0     = cfgq.size();
        popping = m_load;
        if (pipe_rcv_req && !g && m_stall < 65535) m_stall++;
        m_err  = cfg_wr && (sz0 == DEPTH) && !popping;
        m_done = 0;
        if (m_load) begin
            {m_from, m_to} = cfgq.pop_front();
            m_load     = 0;
            m_in_left  = FP;
            m_out_left = FP;
        end else if (m_active) begin
            if (in_x)  m_in_left--;
            if (out_x) m_out_left--;
            if (m_in_left == 0 && m_out_left == 0) begin
                m_done   = 1;
                m_frames = (m_frames + 1) & 16'hFFFF;
                if (sz0 > 0) m_load = 1;
                else         m_active = 0;
            end
        end else if (sz0 > 0) begin
            m_active = 1;
            m_load   = 1;
        end
        if (cfg_wr && (sz0 < DEPTH || popping)) cfgq.push_back({cfg_from_v, cfg_to_v});
        if (pipe_snd_req && pipe_snd_ack && pipe_n > 0) pipe_n--;
        if (in_x) pipe_n++;
    endtask

    task automatic cyc();
        #1;
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit wr, input logic [7:0] f, input logic [7:0] t,
                         input bit ack, input bit rreq);
        cfg_wr       = wr;
        cfg_from_v   = f;
        cfg_to_v     = t;
        up_ack       = ack;
        pipe_rcv_req = rreq;
        pipe_snd_req = $urandom_range(0, 3) != 0;
        pipe_snd_ack = (pipe_n > 0) && ($urandom_range(0, 1) != 0);
    endtask

    task automatic rnd(input int wr_pct);
        drive($urandom_range(0, 99) < wr_pct, 8'($urandom), 8'($urandom),
              $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
    endtask

    initial begin
        int t;
        model_reset();
        rst = 1'b1;
        cfg_wr = 0; cfg_from_v = 0; cfg_to_v = 0;
        up_ack = 1; pipe_rcv_req = 1; pipe_snd_req = 0; pipe_snd_ack = 0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;

        // Idle after reset: no config, upstream requesting, stray output handshakes ignored.
        for (int i = 0; i < 7; i++) begin
            cfg_wr = 0; up_ack = 1; pipe_rcv_req = 1;
            pipe_snd_req = i[0]; pipe_snd_ack = i[0];
            cyc();
        end
        pipe_snd_req = 0; pipe_snd_ack = 0;
`ifdef STATS_EN
        #1;
        chk("stall_after_7", stall_cnt, 16'd7);
`endif

        // Single frame with continuous upstream acknowledge.
        drive(1, 8'd10, 8'd200, 1, 1);
        cyc();
        for (int i = 0; i < 40; i++) begin
            drive(0, 8'd0, 8'd0, 1, 1);
            cyc();
        end

        // Two frames queued back to back.
        drive(1, 8'd10, 8'd200, 1, 1);
        cyc();
        drive(1, 8'd30, 8'd90, 1, 1);
        cyc();
        for (int i = 0; i < 80; i++) begin
            rnd(0);
            cyc();
        end

        // Overflow: A loads, B queued, C written during the pop cycle, D dropped.
        drive(1, 8'h0A, 8'hA0, 0, 1); cyc();
        drive(1, 8'h0B, 8'hB0, 0, 1); cyc();
        drive(1, 8'h0C, 8'hC0, 0, 1); cyc();
        drive(1, 8'h0D, 8'hD0, 0, 1); cyc();
        drive(0, 8'h00, 8'h00, 0, 1); cyc();
        drive(0, 8'h00, 8'h00, 0, 1); cyc();

        // Write into the full FIFO exactly on the next pop cycle.
        t = 0;
        while (!(m_load && cfgq.size() == DEPTH) && t < 200) begin
            rnd(0);
            cyc();
            t++;
        end
        chk("full_load_reached", t < 200, 1'b1);
        drive(1, 8'h0E, 8'hE0, 1, 1);
        cyc();
        for (int i = 0; i < 200; i++) begin
            rnd(0);
            cyc();
        end

        // Reset in the middle of a frame with a second entry still queued.
        drive(1, 8'd5, 8'd6, 1, 1); cyc();
        drive(1, 8'd7, 8'd8, 1, 1); cyc();
        t = 0;
        while (m_in_left != FP - 2 && t < 50) begin
            drive(0, 8'd0, 8'd0, 1, 1);
            pipe_snd_ack = 0;
            cyc();
            t++;
        end
        chk("two_pixels_in", t < 50, 1'b1);
        chk("gate_open_before_rst", up_req, 1'b1);
        #2;
        rst = 1'b1;
        #1;
        chk("up_req_async_rst", up_req, 1'b0);
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(0, 8'd0, 8'd0, 1, 1);
            cyc();
        end

        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            rnd(12);
            cyc();
        end
        #1;
        check_outputs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
